cpu_trace_checker: RTL and testbench
====================================

Name: cpu_trace_checker

Overview:
- Synthesizable end-of-pipe monitor for the CPU's observation outputs (pc, inst, result); the consuming side of the interface the CPU drives every cycle.
- Fetches a golden per-cycle trace from an external synchronous-read ROM and compares it against the live CPU outputs.
- Reports pass/fail, mismatch count and the first failing cycle.
- Sits beside CPU in bench and FPGA builds, sharing its Clock and Reset.

Parameters:
- DEPTH, 64, maximum trace entries checked.
- AW, 6, trace address width; DEPTH <= 2**AW.
- WARMUP, 1, cycles after Reset deasserts during which CPU outputs are ignored; range 0..255.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- pc  in  32  CPU program counter, sampled every cycle.
- inst  in  32  CPU current instruction.
- result  in  32  CPU ALU/writeback result.
- exp_addr  out  AW  golden-ROM read address.
- exp_pc  in  32  ROM data; valid 1 cycle after exp_addr.
- exp_inst  in  32  ROM data; 32'hFFFFFFFF is the end-of-trace sentinel.
- exp_result  in  32  ROM data.
- done  out  1  trace finished (sentinel reached or DEPTH entries compared); sticky.
- pass  out  1  done and zero mismatches.
- fail  out  1  at least one mismatch seen; sticky.
- mismatch_count  out  16  number of mismatching entries; saturates at 16'hFFFF.
- first_fail_idx  out  AW  index of the first mismatching entry.
- first_fail_field  out  3  {pc_bad, inst_bad, result_bad} for the first mismatch.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (Clock, Reset).
- Reset values: every output 0; internal index 0; state WARM.
- States:
  - WARM: counts WARMUP cycles, then enters CHECK. WARMUP=0 enters CHECK on the first cycle after Reset.
  - CHECK, issue stage, cycle n: exp_addr = idx. Register pc/inst/result into obs_q and idx into idx_q. Increment idx.
  - CHECK, compare stage, cycle n+1: if exp_inst == 32'hFFFFFFFF, obs_q is discarded, go DONE. Otherwise compare the three fields.
  - On any mismatch: increment mismatch_count (saturating) and set fail. If this is the first mismatch, latch first_fail_idx = idx_q and first_fail_field.
  - DONE: done=1; pass = (mismatch_count == 0). Terminal until Reset. CPU inputs are ignored; exp_addr holds its last value.
- The comparison pipeline is 1 cycle deep: the entry issued at cycle n is judged at n+1, and done/fail are visible at n+2.
- When the compare of idx_q == DEPTH-1 completes, go DONE. idx never wraps. No issue occurs beyond DEPTH-1: the issue stage stalls once idx == DEPTH-1 has been issued.
- Sentinel seen while other entries are still in flight: the pipeline holds at most one entry, so only the sentinel entry is discarded.
- Simultaneous first mismatch and done: both flags assert in the same cycle; first_fail_* is still latched.
- Reset mid-operation: on the next edge every counter, flag and latch clears; checking restarts from WARM and index 0.
- mismatch_count saturation: holds at FFFF; fail stays 1.

Optional Feature:
- Macro: TRACE_SNAPSHOT_EN.
- Defined: adds outputs snap_pc, snap_inst, snap_result (32 bits each), holding the observed obs_q values of the first mismatching entry. Reset value 0; frozen after capture.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- WARMUP=1, ROM = 4 entries matching the CPU stream exactly (pc 0,4,8,C), entry 4 = sentinel. Required response: done=1, pass=1, fail=0, mismatch_count=0, done asserted 7 cycles after Reset falls.
- Same stream, but ROM entry 2 has exp_result = 32'h5 while the CPU gives 32'h6. Required response: fail=1, first_fail_idx=2, first_fail_field=3'b001, mismatch_count=1, pass=0 at done.
- ROM entries 1 and 3 both have a wrong pc. Required response: mismatch_count=2, first_fail_idx=1, first_fail_field=3'b100.
- No sentinel, DEPTH=8, all entries match. Required response: done after the entry-7 compare, exp_addr never exceeds 7, pass=1.
- Reset pulsed for 1 cycle while idx=3 and fail=1. Required response: next cycle all outputs are 0; a rerun with a matching ROM gives pass=1.
- With TRACE_SNAPSHOT_EN and the mismatch at idx 2 (CPU pc=32'h8, inst=32'h20210001): snap_pc=32'h8, snap_inst=32'h20210001, and both stay unchanged after a later mismatch.

Source files
------------

// File: rtl/cpu_trace_checker.sv
// End-of-pipe monitor: compares live CPU pc/inst/result against a golden trace
// read from an external synchronous ROM. Optional snapshot ports: TRACE_SNAPSHOT_EN.
module cpu_trace_checker #(
  parameter int DEPTH  = 64,
  parameter int AW     = 6,
  parameter int WARMUP = 1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [31:0]   pc,
  input  logic [31:0]   inst,
  input  logic [31:0]   result,
  output logic [AW-1:0] exp_addr,
  input  logic [31:0]   exp_pc,
  input  logic [31:0]   exp_inst,
  input  logic [31:0]   exp_result,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [15:0]   mismatch_count,
  output logic [AW-1:0] first_fail_idx,
  output logic [2:0]    first_fail_field
`ifdef TRACE_SNAPSHOT_EN
  ,
  output logic [31:0]   snap_pc,
  output logic [31:0]   snap_inst,
  output logic [31:0]   snap_result
`endif
);

  typedef enum logic [1:0] {WARM, CHECK, DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [31:0]   SENTINEL  = 32'hFFFF_FFFF;
  localparam logic [7:0]    WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

  state_t        state, state_n;
  logic [7:0]    warm_cnt;
  logic [AW-1:0] idx, idx_q;
  logic          last_issued, valid_q;
  logic [31:0]   obs_pc_q, obs_inst_q, obs_result_q;

  logic          sentinel, mismatch, stop, issue;
  logic [2:0]    bad;

  // Compare stage works on the entry issued last cycle; ROM data is valid now.
  always_comb begin
    sentinel = valid_q && (exp_inst == SENTINEL);
    bad      = {exp_pc != obs_pc_q, exp_inst != obs_inst_q, exp_result != obs_result_q};
    mismatch = valid_q && !sentinel && (bad != 3'b000);
    stop     = valid_q && (sentinel || (idx_q == LAST_IDX));
    issue    = (state == CHECK) && !last_issued && !stop;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) state <= WARM;
    else       state <= state_n;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    case (state)
      WARM:    if (warm_cnt == WARM_LAST) state_n = CHECK;
      CHECK:   if (stop) state_n = DONE;
      DONE:    state_n = DONE;
      default: state_n = WARM;
    endcase
  end

  always_comb begin
    done     = (state == DONE);
    pass     = done && (mismatch_count == 16'd0);
    exp_addr = idx;
  end

  // NOTE: the observation registers are plain flops, not a memory, so they are
  // cleared with everything else to give a deterministic post-reset state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      warm_cnt         <= 8'd0;
      idx              <= '0;
      idx_q            <= '0;
      last_issued      <= 1'b0;
      valid_q          <= 1'b0;
      obs_pc_q         <= 32'd0;
      obs_inst_q       <= 32'd0;
      obs_result_q     <= 32'd0;
      fail             <= 1'b0;
      mismatch_count   <= 16'd0;
      first_fail_idx   <= '0;
      first_fail_field <= 3'b000;
`ifdef TRACE_SNAPSHOT_EN
      snap_pc          <= 32'd0;
      snap_inst        <= 32'd0;
      snap_result      <= 32'd0;
`endif
    end else begin
      if (state == WARM && warm_cnt != WARM_LAST) warm_cnt <= warm_cnt + 8'd1;

      valid_q <= issue;
      if (issue) begin
        obs_pc_q     <= pc;
        obs_inst_q   <= inst;
        obs_result_q <= result;
        idx_q        <= idx;
        // idx parks on the last entry so exp_addr never walks past the trace.
        if (idx == LAST_IDX) last_issued <= 1'b1;
        else                 idx         <= idx + 1'b1;
      end

      if (mismatch) begin
        fail <= 1'b1;
        if (mismatch_count != 16'hFFFF) mismatch_count <= mismatch_count + 16'd1;
        if (!fail) begin
          first_fail_idx   <= idx_q;
          first_fail_field <= bad;
`ifdef TRACE_SNAPSHOT_EN
          snap_pc          <= obs_pc_q;
          snap_inst        <= obs_inst_q;
          snap_result      <= obs_result_q;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Self-checking bench for cpu_trace_checker: a per-entry model pushes expected
// flag/counter states into a scoreboard, popped when the DUT should show them.
module tb_cpu_trace_checker;

  localparam int DEPTH    = 8;
  localparam int AW       = 4;
  localparam int WARMUP   = 1;
  localparam int WARM_CYC = 1;   // cycles the checker spends in WARM for WARMUP=1
  localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;

  logic          Clock, Reset;
  logic [31:0]   pc, inst, result;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_pc, exp_inst, exp_result;
  logic          done, pass, fail;
  logic [15:0]   mismatch_count;
  logic [AW-1:0] first_fail_idx;
  logic [2:0]    first_fail_field;
`ifdef TRACE_SNAPSHOT_EN
  logic [31:0]   snap_pc, snap_inst, snap_result;
`endif

  cpu_trace_checker #(.DEPTH(DEPTH), .AW(AW), .WARMUP(WARMUP)) dut (
    .Clock(Clock), .Reset(Reset),
    .pc(pc), .inst(inst), .result(result),
    .exp_addr(exp_addr), .exp_pc(exp_pc), .exp_inst(exp_inst), .exp_result(exp_result),
    .done(done), .pass(pass), .fail(fail), .mismatch_count(mismatch_count),
    .first_fail_idx(first_fail_idx), .first_fail_field(first_fail_field)
`ifdef TRACE_SNAPSHOT_EN
    , .snap_pc(snap_pc), .snap_inst(snap_inst), .snap_result(snap_result)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Golden trace ROM and CPU stream
  logic [31:0] rom_pc [16], rom_inst [16], rom_result [16];
  logic [31:0] cpu_pc [16], cpu_inst [16], cpu_result [16];

  always_ff @(posedge Clock) begin
    exp_pc     <= rom_pc[exp_addr];
    exp_inst   <= rom_inst[exp_addr];
    exp_result <= rom_result[exp_addr];
  end

  typedef struct {
    int            due;
    logic [15:0]   cnt;
    logic          fail;
    logic          done;
    logic          pass;
    logic [AW-1:0] ffi;
    logic [2:0]    fff;
  } exp_t;

  exp_t sb [$];

  int n_cmp = 0;
  int n_bad = 0;
  int first_done;

  // Reference model state
  int            m_next;
  bit            m_stop, m_done, m_fail;
  logic [15:0]   m_cnt;
  logic [AW-1:0] m_ffi;
  logic [2:0]    m_fff;

  task automatic model_reset();
    m_next = 0; m_stop = 0; m_done = 0; m_fail = 0;
    m_cnt = 16'd0; m_ffi = '0; m_fff = 3'b000;
    sb.delete();
  endtask

  task automatic setup_default();
    for (int j = 0; j < 16; j++) begin
      cpu_pc[j]     = 32'(4 * j);
      cpu_inst[j]   = 32'h2021_0000 + 32'(j);
      cpu_result[j] = 32'(j + 4);
      rom_pc[j]     = cpu_pc[j];
      rom_inst[j]   = cpu_inst[j];
      rom_result[j] = cpu_result[j];
    end
    rom_inst[4] = SENTINEL;
  endtask

  // Holds Reset for three edges; the next run_stream releases it on a negedge.
  task automatic do_reset();
    model_reset();
    @(negedge Clock);
    Reset = 1'b1;
    pc = 32'd0; inst = 32'd0; result = 32'd0;
    repeat (3) @(posedge Clock);
    #1;
  endtask

  task automatic run_stream(input int max_cycles, input bit partial);
    exp_t       e;
    int         j;
    int         hold;
    logic [2:0] bad;
    hold       = 0;
    first_done = -1;
    for (int t = 0; t < max_cycles; t++) begin
      @(negedge Clock);
      Reset = 1'b0;
      if (t >= WARM_CYC && !m_stop) begin
        j = m_next;
        pc = cpu_pc[j]; inst = cpu_inst[j]; result = cpu_result[j];
        if (rom_inst[j] == SENTINEL) begin
          m_done = 1;
        end else begin
          bad = {cpu_pc[j] != rom_pc[j], cpu_inst[j] != rom_inst[j],
                 cpu_result[j] != rom_result[j]};
          if (bad != 3'b000) begin
            if (!m_fail) begin m_ffi = AW'(j); m_fff = bad; end
            m_fail = 1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          end
          if (j == DEPTH - 1) m_done = 1;
        end
        m_stop = m_done;
        m_next++;
        e.due = t + 2; e.cnt = m_cnt; e.fail = m_fail; e.done = m_done;
        e.pass = m_done && (m_cnt == 16'd0); e.ffi = m_ffi; e.fff = m_fff;
        sb.push_back(e);
      end else begin
        pc = $urandom; inst = $urandom; result = $urandom;
      end
      @(posedge Clock);
      #1;
      if (done === 1'b1 && first_done < 0) first_done = t + 1;
      n_cmp++;
      if (exp_addr > AW'(DEPTH - 1)) begin
        n_bad++;
        $display("FAIL exp_addr_bound cycle %0d: got %0d, max %0d", t + 1, exp_addr, DEPTH - 1);
      end
      while (sb.size() > 0 && sb[0].due <= t + 1) begin
        e = sb.pop_front();
        n_cmp++;
        if ({done, pass, fail, mismatch_count, first_fail_idx, first_fail_field} !==
            {e.done, e.pass, e.fail, e.cnt, e.ffi, e.fff}) begin
          n_bad++;
          $display("FAIL sb_state cycle %0d: got done=%b pass=%b fail=%b cnt=%0d ffi=%0d fff=%b, want done=%b pass=%b fail=%b cnt=%0d ffi=%0d fff=%b",
                   t + 1, done, pass, fail, mismatch_count, first_fail_idx, first_fail_field,
                   e.done, e.pass, e.fail, e.cnt, e.ffi, e.fff);
        end
      end
      if (m_stop && sb.size() == 0) begin
        if (hold > 0) begin
          n_cmp++;
          if (done !== 1'b1 || mismatch_count !== m_cnt || fail !== m_fail) begin
            n_bad++;
            $display("FAIL done_hold cycle %0d: got done=%b cnt=%0d fail=%b, want done=1 cnt=%0d fail=%b",
                     t + 1, done, mismatch_count, fail, m_cnt, m_fail);
          end
        end
        hold++;
        if (hold > 3) break;
      end
    end
    if (!partial && (sb.size() != 0 || !m_stop)) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: got %0d pending entries, want 0", sb.size());
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({done, pass, fail, mismatch_count, first_fail_idx, first_fail_field, exp_addr} !== '0) begin
      n_bad++;
      $display("FAIL %s: got done=%b pass=%b fail=%b cnt=%0d ffi=%0d fff=%b addr=%0d, want all 0",
               name, done, pass, fail, mismatch_count, first_fail_idx, first_fail_field, exp_addr);
    end
`ifdef TRACE_SNAPSHOT_EN
    n_cmp++;
    if ({snap_pc, snap_inst, snap_result} !== '0) begin
      n_bad++;
      $display("FAIL %s_snap: got %h %h %h, want 0", name, snap_pc, snap_inst, snap_result);
    end
`endif
  endtask

  task automatic test_reset();
    setup_default();
    do_reset();
    check_all_zero("reset_values");
  endtask

  task automatic test_all_match();
    setup_default();
    do_reset();
    run_stream(40, 0);
    n_cmp++;
    if (first_done != 7) begin
      n_bad++;
      $display("FAIL done_latency: got %0d cycles, want 7", first_done);
    end
    n_cmp++;
    if (pass !== 1'b1 || fail !== 1'b0 || mismatch_count !== 16'd0) begin
      n_bad++;
      $display("FAIL all_match: got pass=%b fail=%b cnt=%0d, want 1 0 0", pass, fail, mismatch_count);
    end
  endtask

  task automatic test_result_mismatch();
    setup_default();
    rom_result[2] = 32'h5;
    do_reset();
    run_stream(40, 0);
    n_cmp++;
    if (fail !== 1'b1 || pass !== 1'b0 || first_fail_idx !== AW'(2) ||
        first_fail_field !== 3'b001 || mismatch_count !== 16'd1) begin
      n_bad++;
      $display("FAIL result_mismatch: got fail=%b pass=%b ffi=%0d fff=%b cnt=%0d, want 1 0 2 001 1",
               fail, pass, first_fail_idx, first_fail_field, mismatch_count);
    end
  endtask

  task automatic test_two_pc_mismatch();
    setup_default();
    rom_pc[1] = 32'h100;
    rom_pc[3] = 32'h300;
    do_reset();
    run_stream(40, 0);
    n_cmp++;
    if (mismatch_count !== 16'd2 || first_fail_idx !== AW'(1) || first_fail_field !== 3'b100) begin
      n_bad++;
      $display("FAIL two_pc_mismatch: got cnt=%0d ffi=%0d fff=%b, want 2 1 100",
               mismatch_count, first_fail_idx, first_fail_field);
    end
  endtask

  task automatic test_no_sentinel();
    setup_default();
    rom_inst[4] = cpu_inst[4];
    do_reset();
    run_stream(60, 0);
    n_cmp++;
    if (first_done != DEPTH + 2 || pass !== 1'b1 || exp_addr !== AW'(DEPTH - 1)) begin
      n_bad++;
      $display("FAIL no_sentinel: got done_at=%0d pass=%b addr=%0d, want %0d 1 %0d",
               first_done, pass, exp_addr, DEPTH + 2, DEPTH - 1);
    end
  endtask

  task automatic test_reset_midrun();
    setup_default();
    rom_pc[1] = 32'h100;
    rom_pc[3] = 32'h300;
    do_reset();
    run_stream(4, 1);
    n_cmp++;
    if (fail !== 1'b1 || exp_addr !== AW'(3)) begin
      n_bad++;
      $display("FAIL midrun_pre: got fail=%b addr=%0d, want 1 3", fail, exp_addr);
    end
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check_all_zero("midrun_reset");
    model_reset();
    setup_default();
    run_stream(40, 0);
    n_cmp++;
    if (pass !== 1'b1 || fail !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_rerun: got pass=%b fail=%b, want 1 0", pass, fail);
    end
  endtask

`ifdef TRACE_SNAPSHOT_EN
  task automatic test_snapshot();
    setup_default();
    cpu_inst[2] = 32'h2021_0001;
    rom_pc[3]   = 32'h300;
    do_reset();
    run_stream(40, 0);
    n_cmp++;
    if (snap_pc !== 32'h8 || snap_inst !== 32'h2021_0001 || snap_result !== 32'h6 ||
        mismatch_count !== 16'd2) begin
      n_bad++;
      $display("FAIL snapshot: got pc=%h inst=%h res=%h cnt=%0d, want 8 20210001 6 2",
               snap_pc, snap_inst, snap_result, mismatch_count);
    end
  endtask
`endif

  initial begin
    Reset = 1'b1;
    pc = 32'd0; inst = 32'd0; result = 32'd0;
    test_reset();
    test_all_match();
    test_result_mismatch();
    test_two_pc_mismatch();
    test_no_sentinel();
    test_reset_midrun();
`ifdef TRACE_SNAPSHOT_EN
    test_snapshot();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
